// File: rtl/timer_pkg.sv
// timer_pkg -- shared definitions for the timer block.
//   Register offsets as seen on addr[3:2], CTRL bit positions,
//   the reset value of divisor/counter and the bus FSM state encoding.
package timer_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_DIVISOR = 2'd1;
    localparam logic [1:0] REG_COUNTER = 2'd2;

    localparam int unsigned CTRL_EXP = 0;
    localparam int unsigned CTRL_IEN = 1;

    localparam logic [31:0] DIVISOR_RST = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

endpackage

// File: rtl/timer_if.sv
// timer_if -- CPU bus between the bus controller (master) and the timer (slave).
//   en       : device selected
//   wr       : 1 = write, 0 = read, valid while en=1
//   addr     : register select (word address bits 3:2)
//   data_in  : write data from CPU
//   data_out : read data to CPU
//   wt       : wait; access completes in the cycle where en=1 and wt=0
interface timer_if;

    logic        en;
    logic        wr;
    logic [3:2]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        wt;

    modport master (
        output en, wr, addr, data_in,
        input  data_out, wt
    );

    modport slave (
        input  en, wr, addr, data_in,
        output data_out, wt
    );

endinterface

// File: rtl/timer_core.sv
// timer_core -- period counter.
//   clk, reset   : clock, asynchronous active-high reset
//   i_load       : load divisor and counter with i_load_val this cycle
//   i_load_val   : value to load
//   o_divisor    : current divisor
//   o_counter    : current counter
//   o_expire     : one-cycle pulse, the counter reloads from divisor at this edge
// A divisor of 0 stops the timer with the counter held at 0.
module timer_core
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    output logic [31:0] o_divisor,
    output logic [31:0] o_counter,
    output logic        o_expire
);

    logic [31:0] r_divisor;
    logic [31:0] r_counter;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_divisor <= DIVISOR_RST;
            r_counter <= DIVISOR_RST;
        end else if (i_load) begin
            r_divisor <= i_load_val;
            r_counter <= i_load_val;
        end else if (r_divisor == 32'd0) begin
            r_counter <= 32'd0;
        end else if (r_counter <= 32'd1) begin
            // Reload on 1; the <= also keeps a stray 0 from wrapping.
            r_counter <= r_divisor;
        end else begin
            r_counter <= r_counter - 32'd1;
        end
    end

    // A load in the same cycle takes priority and suppresses the expiry.
    assign o_expire  = !i_load && (r_divisor != 32'd0) && (r_counter == 32'd1);
    assign o_divisor = r_divisor;
    assign o_counter = r_counter;

endmodule

// File: rtl/timer.sv
// timer -- programmable interval timer with a one-wait-state CPU bus.
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-high reset
//   bus   : timer_if slave (en, wr, addr, data_in, data_out, wt)
//   irq   : level interrupt = expired AND ien
// Registers: CTRL {ien, expired}, DIVISOR (r/w), COUNTER (read-only),
// addr 3 reserved (reads 0, writes ignored).
module timer
    import timer_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    timer_if.slave bus,
    output logic   irq
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ien;
    logic        r_expired;

    logic        w_access;
    logic        w_ctrl_wr;
    logic        w_div_wr;
    logic        w_expire;
    logic [31:0] w_divisor;
    logic [31:0] w_counter;
    logic [31:0] w_rdata;

    timer_core u_core (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_div_wr),
        .i_load_val (bus.data_in),
        .o_divisor  (w_divisor),
        .o_counter  (w_counter),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        bus.wt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.wt = bus.en;
                if (bus.en) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The access completes in ACK only if en is still held; dropping en aborts it.
    assign w_access  = (r_state == ST_ACK) && bus.en;
    assign w_ctrl_wr = w_access && bus.wr && (bus.addr == REG_CTRL);
    assign w_div_wr  = w_access && bus.wr && (bus.addr == REG_DIVISOR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ien     <= 1'b0;
            r_expired <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_ien     <= bus.data_in[CTRL_IEN];
            // An expiry in the same cycle beats a clearing write.
            r_expired <= bus.data_in[CTRL_EXP] | w_expire;
        end else if (w_expire) begin
            r_expired <= 1'b1;
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (r_state == ST_ACK) begin
            case (bus.addr)
                REG_CTRL: begin
                    w_rdata[CTRL_IEN] = r_ien;
                    w_rdata[CTRL_EXP] = r_expired;
                end
                REG_DIVISOR: w_rdata = w_divisor;
                REG_COUNTER: w_rdata = w_counter;
                default:     w_rdata = 32'd0;
            endcase
        end
    end

    assign bus.data_out = w_rdata;
    assign irq          = r_expired & r_ien;

endmodule

// File: tb/tb_timer.sv
// tb_timer -- directed self-checking bench for the timer block.
module tb_timer;
    import timer_pkg::*;

    logic clk;
    logic reset;
    logic irq;
    int   n_checks;
    int   n_errors;

    timer_if bif ();

    timer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif),
        .irq   (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Call just after a rising edge; returns just after the edge ending ACK.
    task automatic access(input logic w, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] q);
        bif.en      = 1'b1;
        bif.wr      = w;
        bif.addr    = a;
        bif.data_in = d;
        @(negedge clk);
        chk("wt_idle", {31'd0, bif.wt}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("wt_ack", {31'd0, bif.wt}, 32'd0);
        q = bif.data_out;
        @(posedge clk);
        #1;
        bif.en = 1'b0;
        bif.wr = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] q;
        access(1'b1, a, d, q);
    endtask

    task automatic rd_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] q;
        access(1'b0, a, 32'd0, q);
        chk(tag, q, exp);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        bif.en      = 1'b0;
        bif.wr      = 1'b0;
        bif.addr    = 2'd0;
        bif.data_in = 32'd0;

        // Outputs while reset is held.
        @(negedge clk);
        chk("rst_wt_en0", {31'd0, bif.wt}, 32'd0);
        chk("rst_dout", bif.data_out, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        bif.en = 1'b1;
        #1;
        chk("rst_wt_en1", {31'd0, bif.wt}, 32'd1);
        bif.en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // CTRL read after reset.
        rd_reg("ctrl_after_rst", REG_CTRL, 32'd0);
        chk("irq_after_rst", {31'd0, irq}, 32'd0);
        rd_reg("div_after_rst", REG_DIVISOR, 32'hFFFF_FFFF);

        // Edge E0 = DIVISOR write edge; counter after Ek = 5 - (k % 5).
        wr_reg(REG_DIVISOR, 32'd5);
        wr_reg(REG_CTRL, 32'd2);              // ien set at E2
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            chk("irq_first_expiry", {31'd0, irq}, (k >= 5) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end

        // Back-to-back COUNTER reads, ACK edges at E8, E10, ... E18.
        bif.en   = 1'b1;
        bif.wr   = 1'b0;
        bif.addr = REG_COUNTER;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("b2b_wt_idle", {31'd0, bif.wt}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            chk("cnt_cycle", bif.data_out, 32'(5 - ((8 + 2 * j) % 5)));
            @(posedge clk);
        end
        #1;
        bif.en = 1'b0;
        chk("irq_sticky", {31'd0, irq}, 32'd1);

        // Acknowledge: write edge E21, no expiry there.
        wr_reg(REG_CTRL, 32'd2);
        chk("irq_ack", {31'd0, irq}, 32'd0);
        rd_reg("ctrl_after_ack", REG_CTRL, 32'd2);
        // Clearing write lands on the E25 expiry.
        wr_reg(REG_CTRL, 32'd2);
        chk("irq_expiry_wins", {31'd0, irq}, 32'd1);
        rd_reg("ctrl_expiry_wins", REG_CTRL, 32'd3);

        // Clear at E32, then DIVISOR=7 lands on the E35 expiry.
        repeat (3) @(posedge clk);
        #1;
        wr_reg(REG_CTRL, 32'd2);
        chk("irq_clear2", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        wr_reg(REG_DIVISOR, 32'd7);
        chk("irq_write_wins", {31'd0, irq}, 32'd0);
        rd_reg("cnt_after_div7", REG_COUNTER, 32'd6);
        rd_reg("div_is_7", REG_DIVISOR, 32'd7);

        // Writes to reserved and read-only registers are ignored.
        wr_reg(2'd3, 32'd0);
        wr_reg(REG_COUNTER, 32'h123);
        rd_reg("cnt_ro", REG_COUNTER, 32'd5);
        rd_reg("div_unchanged", REG_DIVISOR, 32'd7);
        rd_reg("ctrl_unchanged", REG_CTRL, 32'd3);
        rd_reg("addr3_read", 2'd3, 32'd0);

        // Divisor 0 stops the timer.
        begin
            int hits;
            hits = 0;
            wr_reg(REG_DIVISOR, 32'd0);
            wr_reg(REG_CTRL, 32'd2);
            rd_reg("cnt_div0_a", REG_COUNTER, 32'd0);
            repeat (100) begin
                @(negedge clk);
                if (irq) hits++;
            end
            @(posedge clk);
            #1;
            chk("div0_no_irq", 32'(hits), 32'd0);
            rd_reg("cnt_div0_b", REG_COUNTER, 32'd0);
            rd_reg("ctrl_div0", REG_CTRL, 32'd2);
        end

        // Force irq high, then reset during ACK of a DIVISOR write of 3.
        wr_reg(REG_CTRL, 32'd3);
        chk("irq_forced", {31'd0, irq}, 32'd1);
        bif.en      = 1'b1;
        bif.wr      = 1'b1;
        bif.addr    = REG_DIVISOR;
        bif.data_in = 32'd3;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_wt", {31'd0, bif.wt}, 32'd1);
        chk("midrst_dout", bif.data_out, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        bif.en = 1'b0;
        bif.wr = 1'b0;
        @(posedge clk);
        #1;
        rd_reg("div_after_midrst", REG_DIVISOR, 32'hFFFF_FFFF);
        chk("irq_after_midrst", {31'd0, irq}, 32'd0);
        rd_reg("ctrl_after_midrst", REG_CTRL, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
